enemy_spawn_scheduler: RTL
==========================

Name: enemy_spawn_scheduler

Overview:
- Frame-based spawn controller for the three enemy pools (enemy1/enemy2/enemy3).
- Per frame it decides which enemy type to launch and into which free slot, then pulses that pool's trigger/index pair.
- Spawn periods scale with difficulty level, which is derived from the running score.
- Sits between the score/random sources and the enemy pool modules, all in the clk_run domain.

Parameters:
- E1_NUM, 8, enemy1 slot count
- E2_NUM, 4, enemy2 slot count
- E3_NUM, 2, enemy3 slot count
- IDX_BIT_LEN, 3, width of every spawn index output (holds max slot count)
- RAND_WIDTH, 16, random input width
- SCORE_WIDTH, 16, score input width
- P1 / P2 / P3, 32 / 96 / 240, base spawn period per type, in frames
- CNT_BIT_LEN, 9, frame countdown width
- L1 / L2 / L3, 20 / 60 / 150, score thresholds for levels 1 / 2 / 3

Ports:
- clk_run, in, 1, system clock; single clock domain
- rst, in, 1, synchronous active-high reset
- en_i, in, 1, game running; low = idle/flush
- v_sync_i, in, 1, frame sync; rising edge = frame tick
- rand_i, in, RAND_WIDTH, pseudo-random word
- score_i, in, SCORE_WIDTH, current score
- busy1_i, in, E1_NUM, 1 = enemy1 slot occupied (not in unvisual state)
- busy2_i, in, E2_NUM, same for enemy2
- busy3_i, in, E3_NUM, same for enemy3
- spawn1_o / spawn2_o / spawn3_o, out, 1 each, one-cycle trigger pulse per pool
- spawn1_idx_o / spawn2_idx_o / spawn3_idx_o, out, IDX_BIT_LEN each, slot to launch; valid with its pulse, 0 otherwise
- level_o, out, 2, current difficulty level

Behaviour:
- Reset and enable:
  - rst (sampled on clk_run edge): all outputs 0, state IDLE, pending flags 0, rr pointer = type1, counters cnt1/cnt2/cnt3 = P1/P2/P3.
  - en_i low in any state: next cycle is IDLE with the same values as reset. Any spawn pulse already in flight is squashed (no pulse while en_i low).
- Frame tick: tick = v_sync_i & ~v_sync_d (registered edge detect); exactly one tick per rising edge.
- Level: registered each cycle.
  - score_i >= L3 -> 3; >= L2 -> 2; >= L1 -> 1; else 0.
  - Unsigned compare; level_o is that register.
- Type enable:
  - type1 always.
  - type2 when level >= 1.
  - type3 when level >= 2.
  - Disabled types hold their counter and pending flag.
- Reload value: Pk >> level, saturated to minimum 1.
- FSM states: IDLE, COUNT, ARB, FIRE.
  - IDLE -> COUNT when en_i = 1.
  - COUNT: on tick, each enabled type with pending = 0 decrements its counter. If the counter was 1, it reloads and sets pending. -> ARB. Without a tick, stay in COUNT.
  - ARB (1 cycle): scan the three types starting at the rr pointer, wrapping 1 -> 2 -> 3 -> 1. Select the first type with pending = 1, enabled, and at least one busy bit = 0.
    - Slot = lowest index with busy = 0, using busy sampled in this cycle.
    - If found: register type and slot -> FIRE.
    - If not found: -> COUNT. Pending flags are kept and retried next tick.
  - FIRE (1 cycle): the selected spawnN_o = 1 with spawnN_idx_o = slot. Clear that pending flag. rr pointer = selected type + 1 (wrap). -> COUNT.
- Spawn limit: at most one spawn per frame across all types. Remaining pending types wait for later ticks.
- Latency: v_sync_i first sampled high in cycle t -> tick in t+1 -> ARB in t+2 -> pulse in t+3.
- Pending type with full pool: counter does not run and pending stays set; spawns on the first tick after any slot frees.
- Level change mid-count: affects only the next reload, not a running counter.
- Tick arriving in ARB/FIRE: ignored. Minimum v_sync_i period is far larger than 3 cycles.

Optional Feature:
- Macro: ENEMY_SPAWN_JITTER_EN.
- Defined: reload = (Pk >> level) + rand_i[3:0], sampled at reload; initial values after reset/IDLE stay P1/P2/P3.
- Undefined: reload is exactly Pk >> level, fully deterministic; rand_i unused.

Test Plan:
- rst, en_i=1, score 0, all busy 0, ticks every 100 cycles -> spawn1_o single pulse, idx 0, 3 cycles after the 32nd v_sync rise; next at tick 64; spawn2_o/spawn3_o never; level_o=0.
- busy1_i=8'hFF at the 32nd tick -> no pulse; set busy1_i=8'hDF before tick 35 -> spawn1_o at tick 35, idx 5; next spawn1 at tick 35+32.
- score 60 (level 2) with type1 and type2 pending on the same tick -> type1 pulse that frame, type2 idx 0 the next frame; type1 reload 8.
- score 150 -> level_o=3; type1 every 4 ticks, type3 every 30 ticks, idx 0 then 1 while busy3 tracks spawned slots.
- en_i dropped in the cycle ARB would fire -> no pulse; re-enable -> first spawn1 again 32 ticks later.
- rst asserted mid-FIRE -> spawn outputs 0 on the next edge; counters back to P1/P2/P3.

Source files
------------

// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler
//   Frame-based spawn controller for the three enemy pools. On every frame tick the per-type
//   countdowns advance. When one expires, its type becomes pending. At most one pending type is
//   launched per frame. Types are picked round-robin, and the lowest free slot of that pool is used.
//   Spawn periods shrink with the difficulty level, which is derived from the score.
//
// Ports
//   clk_run       : system clock (single domain)
//   rst           : synchronous active-high reset
//   en_i          : game running; low flushes everything back to the reset state
//   v_sync_i      : frame sync, rising edge = frame tick
//   rand_i        : pseudo-random word (only used for reload jitter)
//   score_i       : current score, selects the difficulty level
//   busyN_i       : per-slot occupancy of pool N (1 = occupied)
//   spawnN_o      : one-cycle launch pulse for pool N
//   spawnN_idx_o  : slot to launch, valid with spawnN_o, 0 otherwise
//   level_o       : current difficulty level 0..3
//
// Build option
//   ENEMY_SPAWN_JITTER_EN : when defined, each reload adds rand_i[3:0] frames of jitter.

module enemy_spawn_scheduler #(
   parameter int unsigned E1_NUM      = 8,
   parameter int unsigned E2_NUM      = 4,
   parameter int unsigned E3_NUM      = 2,
   parameter int unsigned IDX_BIT_LEN = 3,
   parameter int unsigned RAND_WIDTH  = 16,
   parameter int unsigned SCORE_WIDTH = 16,
   parameter int unsigned P1          = 32,
   parameter int unsigned P2          = 96,
   parameter int unsigned P3          = 240,
   parameter int unsigned CNT_BIT_LEN = 9,
   parameter int unsigned L1          = 20,
   parameter int unsigned L2          = 60,
   parameter int unsigned L3          = 150
) (
   input  logic                   clk_run,
   input  logic                   rst,
   input  logic                   en_i,
   input  logic                   v_sync_i,
   input  logic [RAND_WIDTH-1:0]  rand_i,
   input  logic [SCORE_WIDTH-1:0] score_i,
   input  logic [E1_NUM-1:0]      busy1_i,
   input  logic [E2_NUM-1:0]      busy2_i,
   input  logic [E3_NUM-1:0]      busy3_i,
   output logic                   spawn1_o,
   output logic                   spawn2_o,
   output logic                   spawn3_o,
   output logic [IDX_BIT_LEN-1:0] spawn1_idx_o,
   output logic [IDX_BIT_LEN-1:0] spawn2_idx_o,
   output logic [IDX_BIT_LEN-1:0] spawn3_idx_o,
   output logic [1:0]             level_o
);

   typedef enum logic [1:0] {StIdle, StCount, StArb, StFire} state_e;
   typedef logic [CNT_BIT_LEN-1:0] cnt_t;

   // Index 0/1/2 corresponds to enemy type 1/2/3 throughout.
   localparam logic [2:0][CNT_BIT_LEN-1:0] CntInit =
      {cnt_t'(P3), cnt_t'(P2), cnt_t'(P1)};

   function automatic cnt_t sat_shift(input int unsigned period, input logic [1:0] lvl);
      int unsigned shifted;
      shifted = period >> lvl;
      if (shifted == 0) shifted = 1;
      return cnt_t'(shifted);
   endfunction

   function automatic logic [1:0] next_type(input logic [1:0] t);
      return (t == 2'd2) ? 2'd0 : t + 2'd1;
   endfunction

   state_e                          state_q, state_d;
   logic                            v_sync_q, v_sync_d;
   logic                            tick_q, tick_d;
   logic [1:0]                      level_q, level_d;
   logic [2:0][CNT_BIT_LEN-1:0]     cnt_q, cnt_d;
   logic [2:0]                      pend_q, pend_d;
   logic [1:0]                      rr_q, rr_d;
   logic [1:0]                      sel_q, sel_d;
   logic [IDX_BIT_LEN-1:0]          sel_idx_q, sel_idx_d;

   logic [2:0]                      type_en;
   logic [2:0][CNT_BIT_LEN-1:0]     reload;
   logic [2:0]                      free;
   logic [IDX_BIT_LEN-1:0]          idx1, idx2, idx3;
   logic [2:0]                      eligible;
   logic                            found;
   logic [1:0]                      pick, cand;
   logic [IDX_BIT_LEN-1:0]          pick_idx;
   logic                            fire;

   // Only rand_i[3:0] feeds the jitter build; the default build ignores it entirely.
   logic unused_rand;
   assign unused_rand = ^rand_i;

   assign type_en = {level_q >= 2'd2, level_q != 2'd0, 1'b1};

   always_comb begin
      reload[0] = sat_shift(P1, level_q);
      reload[1] = sat_shift(P2, level_q);
      reload[2] = sat_shift(P3, level_q);
`ifdef ENEMY_SPAWN_JITTER_EN
      for (int k = 0; k < 3; k++) begin
         reload[k] = reload[k] + cnt_t'(rand_i[3:0]);
      end
`endif
   end

   // Lowest free slot per pool: scan downwards so the lowest zero wins.
   always_comb begin
      free = 3'b000;
      idx1 = '0;
      idx2 = '0;
      idx3 = '0;
      for (int i = int'(E1_NUM) - 1; i >= 0; i--) begin
         if (!busy1_i[i]) begin
            free[0] = 1'b1;
            idx1    = IDX_BIT_LEN'(i);
         end
      end
      for (int i = int'(E2_NUM) - 1; i >= 0; i--) begin
         if (!busy2_i[i]) begin
            free[1] = 1'b1;
            idx2    = IDX_BIT_LEN'(i);
         end
      end
      for (int i = int'(E3_NUM) - 1; i >= 0; i--) begin
         if (!busy3_i[i]) begin
            free[2] = 1'b1;
            idx3    = IDX_BIT_LEN'(i);
         end
      end
   end

   // Round-robin pick starting at rr_q.
   always_comb begin
      eligible = pend_q & type_en & free;
      found    = 1'b0;
      pick     = 2'd0;
      cand     = rr_q;
      for (int j = 0; j < 3; j++) begin
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
         cand = next_type(cand);
      end
      unique case (pick)
         2'd0:    pick_idx = idx1;
         2'd1:    pick_idx = idx2;
         default: pick_idx = idx3;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      v_sync_d  = v_sync_i;
      tick_d    = v_sync_i & ~v_sync_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      rr_d      = rr_q;
      sel_d     = sel_q;
      sel_idx_d = sel_idx_q;

      if (score_i >= SCORE_WIDTH'(L3))      level_d = 2'd3;
      else if (score_i >= SCORE_WIDTH'(L2)) level_d = 2'd2;
      else if (score_i >= SCORE_WIDTH'(L1)) level_d = 2'd1;
      else                                  level_d = 2'd0;

      unique case (state_q)
         StIdle: state_d = StCount;
         StCount: begin
            if (tick_q) begin
               // Pending types freeze their counter until they have been launched.
               for (int k = 0; k < 3; k++) begin
                  if (type_en[k] && !pend_q[k]) begin
                     if (cnt_q[k] == cnt_t'(1)) begin
                        cnt_d[k]  = reload[k];
                        pend_d[k] = 1'b1;
                     end else begin
                        cnt_d[k] = cnt_q[k] - cnt_t'(1);
                     end
                  end
               end
               state_d = StArb;
            end
         end
         StArb: begin
            if (found) begin
               sel_d     = pick;
               sel_idx_d = pick_idx;
               state_d   = StFire;
            end else begin
               state_d = StCount;
            end
         end
         StFire: begin
            pend_d[sel_q] = 1'b0;
            rr_d          = next_type(sel_q);
            state_d       = StCount;
         end
         default: state_d = StIdle;
      endcase

      if (!en_i) begin
         state_d   = StIdle;
         cnt_d     = CntInit;
         pend_d    = 3'b000;
         rr_d      = 2'd0;
         sel_d     = 2'd0;
         sel_idx_d = '0;
         level_d   = 2'd0;
      end
   end

   always_ff @(posedge clk_run) begin
      if (rst) begin
         state_q   <= StIdle;
         v_sync_q  <= 1'b0;
         tick_q    <= 1'b0;
         level_q   <= 2'd0;
         cnt_q     <= CntInit;
         pend_q    <= 3'b000;
         rr_q      <= 2'd0;
         sel_q     <= 2'd0;
         sel_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         v_sync_q  <= v_sync_d;
         tick_q    <= tick_d;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         rr_q      <= rr_d;
         sel_q     <= sel_d;
         sel_idx_q <= sel_idx_d;
      end
   end

   // Gating with en_i squashes a pulse whose FIRE cycle coincides with the enable dropping.
   always_comb begin
      fire         = (state_q == StFire) && en_i;
      spawn1_o     = fire && (sel_q == 2'd0);
      spawn2_o     = fire && (sel_q == 2'd1);
      spawn3_o     = fire && (sel_q == 2'd2);
      spawn1_idx_o = spawn1_o ? sel_idx_q : '0;
      spawn2_idx_o = spawn2_o ? sel_idx_q : '0;
      spawn3_idx_o = spawn3_o ? sel_idx_q : '0;
      level_o      = level_q;
   end

endmodule
